// File: rtl/ahb_lite_pkg.sv
// ============================================================================
// Module      : ahb_lite_pkg
// Description : Shared AHB-Lite encodings and SRAM slave state codes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ahb_lite_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef logic [2:0] slave_state_t;

  localparam slave_state_t S_IDLE = 3'd0;
  localparam slave_state_t S_DATA = 3'd1;
  localparam slave_state_t S_ERR1 = 3'd2;
  localparam slave_state_t S_ERR2 = 3'd3;
  localparam slave_state_t S_WAIT = 3'd4;

endpackage

`default_nettype wire

// File: rtl/ahb_lite_byte_strobe.sv
// ============================================================================
// Module      : ahb_lite_byte_strobe
// Description : Little-endian byte-lane strobe and alignment check per HSIZE.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ahb_lite_byte_strobe
  import ahb_lite_pkg::*;
(
  input  logic [2:0] i_size,
  input  logic [1:0] i_addr_lo,
  output logic [3:0] o_strobe,
  output logic       o_misalign
);

  always_comb begin
    o_strobe   = 4'b0000;
    o_misalign = 1'b0;
    case (i_size)
      HSIZE_BYTE: o_strobe = 4'b0001 << i_addr_lo;
      HSIZE_HALF: begin
        o_strobe   = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_misalign = i_addr_lo[0];
      end
      HSIZE_WORD: begin
        o_strobe   = 4'b1111;
        o_misalign = |i_addr_lo;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/ahb_lite_sram_slave.sv
// ============================================================================
// Module      : ahb_lite_sram_slave
// Description : AHB-Lite single-port SRAM slave with OKAY/two-cycle ERROR.
//               Define AHB_SLAVE_WAIT_EN to insert WAIT_CYCLES wait states.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ahb_lite_sram_slave
  import ahb_lite_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [DATA_WIDTH-1:0] HADDR,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [1:0]            HTRANS,
  input  logic                  HMASTLOCK,
  input  logic                  HREADY,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  output logic [DATA_WIDTH-1:0] HRDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP
);

  localparam int                    AW          = $clog2(MEM_DEPTH);
  localparam logic [DATA_WIDTH-1:0] C_MEM_BYTES = DATA_WIDTH'(MEM_DEPTH * 4);

  slave_state_t          r_state;
  logic                  r_write;
  logic [AW-1:0]         r_idx;
  logic [3:0]            r_strobe;
  logic [DATA_WIDTH-1:0] r_hrdata;
  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  logic [3:0]   w_strobe;
  logic         w_misalign;
  logic         w_hreadyout;
  logic         w_accept;
  logic         w_err;
  slave_state_t w_ok_state;
  logic         w_unused;

  ahb_lite_byte_strobe u_strobe (
    .i_size     (HSIZE),
    .i_addr_lo  (HADDR[1:0]),
    .o_strobe   (w_strobe),
    .o_misalign (w_misalign)
  );

  assign w_hreadyout = (r_state != S_ERR1) && (r_state != S_WAIT);
  assign w_accept    = HSEL && HREADY && HTRANS[1] && w_hreadyout;
  assign w_err       = (HSIZE > HSIZE_WORD) || (HADDR >= C_MEM_BYTES) || w_misalign;

`ifdef AHB_SLAVE_WAIT_EN
  localparam logic [7:0] C_WAIT_LAST = 8'(WAIT_CYCLES - 1);
  logic [7:0] r_cnt;

  assign w_ok_state = (WAIT_CYCLES != 0) ? S_WAIT : S_DATA;
  assign w_unused   = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0]};
`else
  assign w_ok_state = S_DATA;
  assign w_unused   = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0], 32'(WAIT_CYCLES)};
`endif

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_state  <= S_IDLE;
      r_write  <= 1'b0;
      r_idx    <= '0;
      r_strobe <= 4'b0000;
`ifdef AHB_SLAVE_WAIT_EN
      r_cnt    <= 8'd0;
`endif
    end else begin
      case (r_state)
        S_ERR1: r_state <= S_ERR2;
`ifdef AHB_SLAVE_WAIT_EN
        S_WAIT: begin
          if (r_cnt == C_WAIT_LAST) r_state <= S_DATA;
          else                      r_cnt   <= r_cnt + 8'd1;
        end
`endif
        // IDLE, DATA and ERR2 all drive HREADYOUT high, so each can take a new address phase
        default: begin
          if (w_accept) begin
            r_write  <= HWRITE;
            r_idx    <= HADDR[AW+1:2];
            r_strobe <= w_strobe;
            r_state  <= w_err ? S_ERR1 : w_ok_state;
`ifdef AHB_SLAVE_WAIT_EN
            r_cnt    <= 8'd0;
`endif
          end else begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge HCLK) begin
    if (r_state == S_DATA && r_write) begin
      for (int b = 0; b < 4; b++) begin
        if (r_strobe[b]) r_mem[r_idx][8*b +: 8] <= HWDATA[8*b +: 8];
      end
    end
  end

  // Read data comes straight from the array so a write committed at the previous edge is visible
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET)                               r_hrdata <= '0;
    else if (r_state == S_DATA && !r_write)   r_hrdata <= r_mem[r_idx];
  end

  assign HRDATA    = (r_state == S_DATA && !r_write) ? r_mem[r_idx] : r_hrdata;
  assign HREADYOUT = w_hreadyout;
  assign HRESP     = (r_state == S_ERR1 || r_state == S_ERR2) ? HRESP_ERROR : HRESP_OKAY;

endmodule

`default_nettype wire

// File: tb/tb_ahb_lite_sram_slave.sv
// ============================================================================
// Module      : tb_ahb_lite_sram_slave
// Description : Self-checking bench for ahb_lite_sram_slave (AHB_SLAVE_WAIT_EN aware).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ahb_lite_sram_slave;

`ifdef AHB_SLAVE_WAIT_EN
  localparam int EXP_W = 2;
`else
  localparam int EXP_W = 0;
`endif

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        HSEL;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic [1:0]  HTRANS;
  logic        HMASTLOCK;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;

  int checks   = 0;
  int failures = 0;
  logic [31:0] model [256];

  always #5 HCLK = ~HCLK;

  ahb_lite_sram_slave #(.DATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_CYCLES(2)) dut (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .HSEL      (HSEL),
    .HADDR     (HADDR),
    .HWRITE    (HWRITE),
    .HSIZE     (HSIZE),
    .HBURST    (HBURST),
    .HPROT     (HPROT),
    .HTRANS    (HTRANS),
    .HMASTLOCK (HMASTLOCK),
    .HREADY    (HREADYOUT),
    .HWDATA    (HWDATA),
    .HRDATA    (HRDATA),
    .HREADYOUT (HREADYOUT),
    .HRESP     (HRESP)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_err(input logic [31:0] a, input logic [2:0] s);
    int nb;
    nb = 1 << s;
    return (s > 3'd2) || (a >= 32'd1024) || ((a % nb) != 0);
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [2:0] s, input logic [31:0] d);
    int nb, lo, w;
    nb = 1 << s;
    lo = int'(a % 4);
    w  = int'(a / 4);
    for (int i = 0; i < 4; i++)
      if (i >= lo && i < lo + nb) model[w][8*i +: 8] = d[8*i +: 8];
  endtask

  // Starts and ends at a negedge; samples the data phase at each negedge until HREADYOUT=1.
  task automatic do_xfer(input logic wr, input logic [31:0] a, input logic [2:0] s,
                         input logic [31:0] d, input logic poke,
                         output logic [31:0] rdata, output logic resp,
                         output int waits, output logic resp_low);
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = a; HWRITE = wr; HSIZE = s;
    @(negedge HCLK);
    HSEL = 1'b0; HTRANS = 2'b00; HWDATA = d;
    waits = 0; resp_low = 1'b0;
    while (HREADYOUT !== 1'b1 && waits < 20) begin
      waits++;
      resp_low = resp_low | HRESP;
      if (poke) begin
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h30; HWRITE = 1'b1; HSIZE = 3'd2;
      end
      @(negedge HCLK);
    end
    HSEL = 1'b0; HTRANS = 2'b00;
    rdata = HRDATA;
    resp  = HRESP;
    @(negedge HCLK);
  endtask

  task automatic run_check(input string tag, input logic wr, input logic [31:0] a,
                           input logic [2:0] s, input logic [31:0] d, input logic poke);
    logic [31:0] rd;
    logic        rsp, rl, e;
    int          w;
    e = exp_err(a, s);
    do_xfer(wr, a, s, d, poke, rd, rsp, w, rl);
    chk({tag, ".resp"}, 32'(rsp), 32'(e));
    chk({tag, ".waits"}, 32'(w), e ? 32'd1 : 32'(EXP_W));
    chk({tag, ".resp_low"}, 32'(rl), 32'(e));
    if (!e && !wr) chk({tag, ".rdata"}, rd, model[a / 4]);
    if (!e && wr) model_write(a, s, d);
  endtask

  task automatic rd_expect(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] rd;
    logic        rsp, rl;
    int          w;
    do_xfer(1'b0, a, 3'd2, 32'h0, 1'b0, rd, rsp, w, rl);
    chk({tag, ".rdata"}, rd, exp);
    chk({tag, ".resp"}, 32'(rsp), 32'd0);
    chk({tag, ".waits"}, 32'(w), 32'(EXP_W));
  endtask

  initial begin
    int          n;
    logic [31:0] a, d;
    logic [2:0]  s;
    logic        wr;

    HRESET = 1'b1; HSEL = 1'b0; HADDR = '0; HWRITE = 1'b0; HSIZE = 3'd0;
    HBURST = 3'd0; HPROT = 4'd0; HTRANS = 2'b00; HMASTLOCK = 1'b0; HWDATA = '0;
    for (int i = 0; i < 256; i++) model[i] = 32'h0;

    @(negedge HCLK);
    @(negedge HCLK);
    chk("reset.hreadyout", 32'(HREADYOUT), 32'd1);
    chk("reset.hresp", 32'(HRESP), 32'd0);
    chk("reset.hrdata", HRDATA, 32'h0);
    HRESET = 1'b0;
    @(negedge HCLK);

    // Initialise words 0..15 so later reads are always defined
    for (int i = 0; i < 16; i++) run_check("init", 1'b1, 32'(i * 4), 3'd2, $urandom, 1'b0);

    // Word / byte / half writes with fixed read-back values
    run_check("t1.wr", 1'b1, 32'h10, 3'd2, 32'hDEADBEEF, 1'b0);
    rd_expect("t1.rd", 32'h10, 32'hDEADBEEF);
    run_check("t2.wrb", 1'b1, 32'h11, 3'd0, 32'h0000AB00, 1'b0);
    rd_expect("t2.rdb", 32'h10, 32'hDEADABEF);
    run_check("t2.wrh", 1'b1, 32'h12, 3'd1, 32'h12340000, 1'b0);
    rd_expect("t2.rdh", 32'h10, 32'h1234ABEF);

    // Error responses: out-of-range read, misaligned word write
    run_check("t3.oor", 1'b0, 32'h400, 3'd2, 32'h0, 1'b0);
    run_check("t3.mis", 1'b1, 32'h02, 3'd2, 32'hFFFFFFFF, 1'b0);
    run_check("t3.rd0", 1'b0, 32'h00, 3'd2, 32'h0, 1'b0);

    // Pipelined write then read of the same word
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h20; HWRITE = 1'b1; HSIZE = 3'd2;
    @(negedge HCLK);
    HWDATA = 32'hCAFEF00D; HADDR = 32'h20; HWRITE = 1'b0;
    n = 0;
    while (HREADYOUT !== 1'b1 && n < 20) begin @(negedge HCLK); n++; end
    chk("t4.wr_waits", 32'(n), 32'(EXP_W));
    @(negedge HCLK);
    HSEL = 1'b0; HTRANS = 2'b00;
    n = 0;
    while (HREADYOUT !== 1'b1 && n < 20) begin @(negedge HCLK); n++; end
    chk("t4.rd_waits", 32'(n), 32'(EXP_W));
    chk("t4.rdata", HRDATA, 32'hCAFEF00D);
    chk("t4.resp", 32'(HRESP), 32'd0);
    @(negedge HCLK);
    model[8] = 32'hCAFEF00D;

    // Reset while in the first ERROR cycle
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h02; HWRITE = 1'b1; HSIZE = 3'd2;
    @(negedge HCLK);
    HSEL = 1'b0; HTRANS = 2'b00; HWDATA = 32'h0BADF00D;
    chk("t5.err1_ready", 32'(HREADYOUT), 32'd0);
    chk("t5.err1_resp", 32'(HRESP), 32'd1);
    #2 HRESET = 1'b1;
    #1;
    chk("t5.rst_ready", 32'(HREADYOUT), 32'd1);
    chk("t5.rst_resp", 32'(HRESP), 32'd0);
    chk("t5.rst_hrdata", HRDATA, 32'h0);
    #1 HRESET = 1'b0;
    @(negedge HCLK);
    chk("t5.post_ready", 32'(HREADYOUT), 32'd1);
    chk("t5.post_resp", 32'(HRESP), 32'd0);
    run_check("t5.rd0", 1'b0, 32'h00, 3'd2, 32'h0, 1'b0);

    // Reset during the data phase of a valid write: it must not commit
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h24; HWRITE = 1'b1; HSIZE = 3'd2;
    @(negedge HCLK);
    HSEL = 1'b0; HTRANS = 2'b00; HWDATA = 32'h55AA55AA;
    #2 HRESET = 1'b1;
    #2 HRESET = 1'b0;
    @(negedge HCLK);
    run_check("t5.rd24", 1'b0, 32'h24, 3'd2, 32'h0, 1'b0);

    // Address presented during wait states must be ignored
    run_check("t6.poke", 1'b0, 32'h10, 3'd2, 32'h0, 1'b1);
    run_check("t6.rd30", 1'b0, 32'h30, 3'd2, 32'h0, 1'b0);

    // Randomised traffic against the reference model
    for (int k = 0; k < 60; k++) begin
      wr = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) a = 32'h400 + 32'($urandom_range(0, 255));
      else                           a = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 7) == 0) s = 3'd3;
      else                           s = 3'($urandom_range(0, 2));
      d = $urandom;
      run_check("rand", wr, a, s, d, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ahb_lite_sram_slave.md
Name: ahb_lite_sram_slave

Overview:
AHB-Lite single-port SRAM slave; the downstream consumer of transfers issued by the task-driven AHB-Lite master.
- Decodes address/control phases, performs word, halfword and byte reads and writes into an internal register array.
- Returns OKAY or two-cycle ERROR responses.
- Single-slave systems tie the master's HREADY to this block's HREADYOUT.

Parameters:
- DATA_WIDTH, 32: HWDATA/HRDATA/HADDR width (equals `BUS_WIDTH); only 32 supported.
- MEM_DEPTH, 256: number of 32-bit words; valid byte range 0 .. MEM_DEPTH*4-1.
- WAIT_CYCLES, 2: wait states per read/write data phase; used only with AHB_SLAVE_WAIT_EN.

Ports:
- HCLK  in  1  bus clock, all state on rising edge.
- HRESET  in  1  asynchronous active-high reset.
- HSEL  in  1  slave select.
- HADDR  in  32  byte address.
- HWRITE  in  1  1=write.
- HSIZE  in  3  0=byte, 1=half, 2=word.
- HBURST  in  3  ignored.
- HPROT  in  4  ignored.
- HTRANS  in  2  IDLE/BUSY/NONSEQ/SEQ.
- HMASTLOCK  in  1  ignored.
- HREADY  in  1  bus-level ready.
- HWDATA  in  32  write data, valid in data phase.
- HRDATA  out  32  read data.
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  0=OKAY, 1=ERROR.

Behaviour:
- Reset (async, HRESET=1):
  - State=S_IDLE, HREADYOUT=1, HRESP=0, HRDATA=0.
  - Phase registers cleared; memory contents not cleared.
  - Reset mid-transfer aborts it; no memory write commits.
- Accept: at posedge with HSEL && HREADY && HTRANS[1]=1 (NONSEQ/SEQ). Register addr, write, size, and error flag into the phase registers.
- Not accepted: IDLE, BUSY, HSEL=0 or HREADY=0. No data phase; next cycle OKAY with zero wait.
- Error flag set when any of:
  - HSIZE>2
  - HADDR >= MEM_DEPTH*4
  - half with HADDR[0]=1
  - word with HADDR[1:0]!=0
- FSM states:
  - S_IDLE: no pending data phase. Accept with error -> S_ERR1. Accept without error -> S_DATA (or S_WAIT with the optional feature).
  - S_DATA: HREADYOUT=1, HRESP=0. Write commits at this edge using byte strobes. Read: HRDATA = mem[addr[31:2]], whole word, all lanes. The same edge may accept the next address phase; otherwise -> S_IDLE.
  - S_ERR1: HREADYOUT=0, HRESP=1; -> S_ERR2.
  - S_ERR2: HREADYOUT=1, HRESP=1; memory untouched. The transfer presented this cycle is accepted normally, because HREADY=1.
- Byte strobes (little-endian):
  - byte: strobe = 1 << addr[1:0]
  - half: 0011 or 1100 by addr[1]
  - word: 1111
  - Unstrobed bytes keep their old value.
- Write-then-read to the same address back-to-back: the read data phase returns the newly written data, since the write committed at the preceding edge.
- While HREADYOUT=0, address-phase inputs are ignored.
- HRDATA holds its last value outside read data phases.

Optional Feature:
- AHB_SLAVE_WAIT_EN defined:
  - Adds state S_WAIT and a counter.
  - After acceptance, HREADYOUT=0 and HRESP=0 for WAIT_CYCLES cycles, then S_DATA.
  - WAIT_CYCLES=0 behaves as undefined.
  - Error transfers skip S_WAIT.
- Undefined: zero-wait OKAY on every non-error transfer; WAIT_CYCLES is unused.

Decomposition:
- Package ahb_lite_pkg:
  - HTRANS encodings (IDLE, BUSY, NONSEQ, SEQ).
  - HSIZE codes.
  - HRESP OKAY/ERROR.
  - slave state enum.
  - Shares values with AHB_Lite_defines.sv.
- Sub-module ahb_lite_byte_strobe: combinational; HSIZE and addr[1:0] in, 4-bit strobe plus misalign flag out.

Test Plan:
1. Word write 0x10 = 0xDEADBEEF, then read 0x10 -> HRDATA=0xDEADBEEF, HRESP=0, HREADYOUT never low.
2. Byte write HSIZE=0 to 0x11 with HWDATA=0x0000AB00, then read 0x10 -> 0xDEADABEF; half write 0x12 with 0x12340000 -> read 0x12ABEF... verify 0x1234ABEF.
3. Read of 0x400 (MEM_DEPTH=256) -> cycle1 HREADYOUT=0/HRESP=1, cycle2 HREADYOUT=1/HRESP=1; word write to 0x02 -> same ERROR sequence, memory at 0x00 unchanged.
4. Pipelined NONSEQ write 0x20=0xCAFEF00D followed directly by NONSEQ read 0x20 -> read data phase returns 0xCAFEF00D with no stall.
5. HRESET pulsed during S_ERR1 -> after release HREADYOUT=1, HRESP=0, state S_IDLE; pending write never committed.
6. With AHB_SLAVE_WAIT_EN, WAIT_CYCLES=2: read 0x10 -> exactly 2 cycles HREADYOUT=0, then data with HREADYOUT=1; an address presented during a wait is ignored.
